move_controller: RTL
====================

// Module: move_controller
// PURPOSE
//  Game-move sequencer upstream of the win checker. Accepts a column request, finds the landing row,
//  commits the piece into the 42-bit player/occupancy boards and presents (location, height, player, boards).
//  Waits for the combinational win verdict, then ends the game (win/draw) or hands the turn over.
// PARAMETERS
//  COLS      7  board columns; location range 0..COLS-1
//  ROWS      6  board rows; height range 0..ROWS-1 (0 = bottom)
//  WIN_WAIT  1  cycles EVAL waits after commit before sampling wongame (>=1)
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  resetn           in   1   asynchronous, active-low reset
//  new_game         in   1   sync clear of board/game state; priority over everything except resetn
//  move_valid       in   1   move request valid
//  move_col         in   3   requested column
//  move_ready       out  1   high only in IDLE while game not over
//  move_reject      out  1   1-cycle pulse: request illegal (col>=COLS or column full)
//  location         out  3   column of last committed piece (to win checker)
//  height           out  3   row of last committed piece (to win checker)
//  player           out  1   player owning current turn / last piece while in EVAL
//  player_register  out  42  bit set = piece belongs to player 1; valid only where onoff bit set
//  onoff_register   out  42  bit set = cell occupied
//  wongame          in   1   win verdict for (location,height,player,boards), combinational
//  game_over        out  1   level, set on win or draw until new_game/reset
//  winner           out  1   winning player, valid when game_over & ~draw
//  draw             out  1   level, board full with no win
// BEHAVIOUR
//  Cell index = location*ROWS + height (column-major, bit 0 = column 0 bottom).
//  Reset/new_game: boards=0, col heights=0, move count=0, player=0, location=height=0,
//   game_over=winner=draw=move_reject=0, state IDLE. Mid-operation reset aborts any move, no partial commit.
//  State: per-column fill counter colh[c] (0..ROWS), move counter mcnt (0..COLS*ROWS).
//  FSM IDLE -> CHECK -> {IDLE | PLACE} -> EVAL -> {IDLE | OVER}:
//   IDLE : move_ready=1 (if !game_over). On move_valid&move_ready latch move_col -> CHECK. Else hold.
//   CHECK: if col>=COLS or colh[col]==ROWS: pulse move_reject for this cycle, -> IDLE, no state change.
//          else location<=col, height<=colh[col] -> PLACE.
//   PLACE: set onoff_register[idx]=1, player_register[idx]=player; colh[col]++, mcnt++ -> EVAL.
//   EVAL : wait WIN_WAIT cycles (counter), then sample wongame:
//          1 -> game_over=1, winner=player -> OVER.
//          0 & mcnt==COLS*ROWS -> game_over=1, draw=1 -> OVER.
//          0 otherwise -> player<=~player -> IDLE.
//   OVER : move_ready=0, move_valid ignored; exits only on new_game (-> IDLE) or resetn.
//  Accept-to-commit latency: request accepted edge N, boards updated edge N+2, verdict sampled edge N+2+WIN_WAIT.
//  location/height/player stable through EVAL; never change outside CHECK/EVAL transitions.
//  move_valid outside IDLE ignored (not queued). new_game concurrent with move_valid: new_game wins.
//  A win on the 42nd piece reports winner, draw=0 (win checked before draw).
//  Already-set board bits never cleared except by new_game/reset; colh never exceeds ROWS.
// TESTING
//  1 Reset: resetn low -> all outputs 0, move_ready=1 after release.
//  2 Vertical win: P0 col3, P1 col4 alternating x3, then P0 col3 -> wongame model asserted, game_over=1,
//    winner=0, onoff bits 18,19,20,21 set; further move_valid ignored.
//  3 Full column: 6 legal drops into col0 then 7th -> move_reject pulse 1 cycle, player unchanged, boards unchanged.
//  4 Illegal column: move_col=7 -> move_reject, no commit; move_col=6 next -> height=0, bit 36 set.
//  5 Draw: 42 moves with wongame forced 0 -> draw=1, game_over=1, onoff_register=all ones.
//  6 Abort: resetn low during EVAL, and new_game during CHECK -> boards cleared, no commit, state IDLE.

Source files
------------

// File: rtl/move_controller.sv
// Move sequencer for a column-drop board game: validates a column request, commits the piece
// into the player/occupancy boards, waits for the external win verdict, then ends or passes the turn.
module move_controller #(
    parameter int COLS     = 7,
    parameter int ROWS     = 6,
    parameter int WIN_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 new_game,
    input  logic                 move_valid,
    input  logic [2:0]           move_col,
    output logic                 move_ready,
    output logic                 move_reject,
    output logic [2:0]           location,
    output logic [2:0]           height,
    output logic                 player,
    output logic [COLS*ROWS-1:0] player_register,
    output logic [COLS*ROWS-1:0] onoff_register,
    input  logic                 wongame,
    output logic                 game_over,
    output logic                 winner,
    output logic                 draw
);
    localparam int CELLS = COLS * ROWS;
    localparam int MW    = $clog2(CELLS + 1);
    localparam int IW    = $clog2(CELLS);
    localparam int WW    = (WIN_WAIT > 1) ? $clog2(WIN_WAIT) : 1;

    localparam logic [3:0]    COLS_L    = 4'(COLS);
    localparam logic [3:0]    ROWS_L    = 4'(ROWS);
    localparam logic [MW-1:0] CELLS_L   = MW'(CELLS);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WIN_WAIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PLACE, S_EVAL, S_OVER} state_t;

    state_t            state_q, state_d;
    logic [2:0]        col_q, col_d;
    logic [3:0]        colh_q [COLS];
    logic [3:0]        colh_d [COLS];
    logic [MW-1:0]     mcnt_q, mcnt_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              player_q, player_d;
    logic [2:0]        loc_q, loc_d;
    logic [2:0]        hgt_q, hgt_d;
    logic [CELLS-1:0]  preg_q, preg_d;
    logic [CELLS-1:0]  onoff_q, onoff_d;
    logic              over_q, over_d;
    logic              winner_q, winner_d;
    logic              draw_q, draw_d;

    logic [3:0]        col_fill;
    logic              col_illegal;
    logic [IW-1:0]     idx;

    // An out-of-range column reads as full, so one test covers both rejection causes.
    always_comb begin
        col_fill = ROWS_L;
        for (int i = 0; i < COLS; i++) begin
            if (col_q == 3'(i)) begin
                col_fill = colh_q[i];
            end
        end
    end

    assign col_illegal = ({1'b0, col_q} >= COLS_L) || (col_fill >= ROWS_L);
    assign idx         = IW'(loc_q) * IW'(ROWS) + IW'(hgt_q);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        colh_d      = colh_q;
        mcnt_d      = mcnt_q;
        wcnt_d      = wcnt_q;
        player_d    = player_q;
        loc_d       = loc_q;
        hgt_d       = hgt_q;
        preg_d      = preg_q;
        onoff_d     = onoff_q;
        over_d      = over_q;
        winner_d    = winner_q;
        draw_d      = draw_q;
        move_reject = 1'b0;
        move_ready  = (state_q == S_IDLE) && !over_q;

        case (state_q)
            S_IDLE: begin
                if (move_valid && move_ready) begin
                    col_d   = move_col;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (col_illegal) begin
                    move_reject = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    loc_d   = col_q;
                    hgt_d   = col_fill[2:0];
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                onoff_d[idx]  = 1'b1;
                preg_d[idx]   = player_q;
                colh_d[loc_q] = colh_q[loc_q] + 4'd1;
                mcnt_d        = mcnt_q + MW'(1);
                wcnt_d        = '0;
                state_d       = S_EVAL;
            end
            S_EVAL: begin
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d = '0;
                    // Win is tested before draw so a winning last piece is not a draw.
                    if (wongame) begin
                        over_d   = 1'b1;
                        winner_d = player_q;
                        state_d  = S_OVER;
                    end else if (mcnt_q == CELLS_L) begin
                        over_d  = 1'b1;
                        draw_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        player_d = ~player_q;
                        state_d  = S_IDLE;
                    end
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (new_game) begin
            state_d     = S_IDLE;
            col_d       = '0;
            colh_d      = '{default: '0};
            mcnt_d      = '0;
            wcnt_d      = '0;
            player_d    = 1'b0;
            loc_d       = '0;
            hgt_d       = '0;
            preg_d      = '0;
            onoff_d     = '0;
            over_d      = 1'b0;
            winner_d    = 1'b0;
            draw_d      = 1'b0;
            move_reject = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            mcnt_q   <= '0;
            wcnt_q   <= '0;
            player_q <= 1'b0;
            loc_q    <= '0;
            hgt_q    <= '0;
            preg_q   <= '0;
            onoff_q  <= '0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
            draw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            mcnt_q   <= mcnt_d;
            wcnt_q   <= wcnt_d;
            player_q <= player_d;
            loc_q    <= loc_d;
            hgt_q    <= hgt_d;
            preg_q   <= preg_d;
            onoff_q  <= onoff_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_colh
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                colh_q[gi] <= '0;
            end else begin
                colh_q[gi] <= colh_d[gi];
            end
        end
    end

    assign location        = loc_q;
    assign height          = hgt_q;
    assign player          = player_q;
    assign player_register = preg_q;
    assign onoff_register  = onoff_q;
    assign game_over       = over_q;
    assign winner          = winner_q;
    assign draw            = draw_q;

endmodule
